// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions: counter width, state codes, baud table.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int c_CNT_W = 19;

    typedef logic [c_CNT_W-1:0] cnt_t;
    typedef logic [3:0]         state_t;

    localparam state_t c_ST_IDLE   = 4'd0;
    localparam state_t c_ST_START  = 4'd1;
    localparam state_t c_ST_BIT0   = 4'd2;
    localparam state_t c_ST_BIT7   = 4'd9;
    localparam state_t c_ST_PARITY = 4'd10;
    localparam state_t c_ST_STOP   = 4'd11;

    function automatic int unsigned baud_rate(input logic [2:0] sel);
        int unsigned rate;
        case (sel)
            3'd0:    rate = 300;
            3'd1:    rate = 1200;
            3'd2:    rate = 4800;
            3'd3:    rate = 9600;
            3'd4:    rate = 19200;
            3'd5:    rate = 38400;
            3'd6:    rate = 57600;
            default: rate = 115200;
        endcase
        return rate;
    endfunction

    // Rounded clock cycles per bit; only ever evaluated at elaboration.
    function automatic cnt_t baud_div(input int unsigned clk_hz, input logic [2:0] sel);
        int unsigned rate;
        rate = baud_rate(sel);
        return cnt_t'((clk_hz + rate / 2) / rate);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_transmitter_baud.sv
`default_nettype none
// ============================================================================
// Module   : baud_controller_t
// Purpose  : Emits a one-cycle tick every DIV clocks; DIV latched on load.
// Revision : 1.0
// ============================================================================
module baud_controller_t
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [2:0] i_baud_sel,
    output logic       o_tick
);

    cnt_t w_div_table [8];
    cnt_t r_div;
    cnt_t r_count;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_div
            localparam cnt_t c_DIV = baud_div(CLK_FREQ_HZ, 3'(gi));
            assign w_div_table[gi] = c_DIV;
        end
    endgenerate

    assign o_tick = (r_count == r_div - cnt_t'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div   <= '0;
            r_count <= '0;
        end else begin
            if (i_load)
                r_div <= w_div_table[i_baud_sel];
            if (i_clear || o_tick)
                r_count <= '0;
            else
                r_count <= r_count + cnt_t'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : uart_transmitter
// Purpose  : 8E1 UART transmitter with selectable baud rate and abort on disable.
// Revision : 1.0
// ============================================================================
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Tx_EN,
    input  logic       Tx_WR,
    input  logic [7:0] Tx_DATA,
    output logic       TxD,
    output logic       Tx_BUSY
);

    state_t     r_state;
    state_t     w_next_state;
    state_t     w_bit_idx;
    logic [7:0] r_data;
    logic       w_accept;
    logic       w_tick;
    logic       w_next_txd;

    assign w_accept  = Tx_WR & Tx_EN & ~Tx_BUSY & (r_state == c_ST_IDLE);
    assign w_bit_idx = w_next_state - c_ST_BIT0;

    baud_controller_t #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ)
    ) u_baud (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_accept | ~Tx_EN),
        .i_load     (w_accept),
        .i_baud_sel (baud_select),
        .o_tick     (w_tick)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept)
                    w_next_state = c_ST_START;
            end
            c_ST_START, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, c_ST_PARITY: begin
                if (w_tick)
                    w_next_state = r_state + 4'd1;
            end
            c_ST_STOP: begin
                if (w_tick)
                    w_next_state = c_ST_IDLE;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
        if (!Tx_EN)
            w_next_state = c_ST_IDLE;
    end

    // Line level is decoded from the next state so TxD stays in step with r_state.
    always_comb begin
        w_next_txd = 1'b1;
        if (w_next_state == c_ST_START)
            w_next_txd = 1'b0;
        else if (w_next_state >= c_ST_BIT0 && w_next_state <= c_ST_BIT7)
            w_next_txd = r_data[w_bit_idx[2:0]];
        else if (w_next_state == c_ST_PARITY)
            w_next_txd = ^r_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            TxD     <= 1'b1;
            Tx_BUSY <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_next_state;
            TxD     <= w_next_txd;
            Tx_BUSY <= (w_next_state != c_ST_IDLE);
            if (w_accept)
                r_data <= Tx_DATA;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_transmitter
// Purpose  : Directed frame-level checks of uart_transmitter at a 1 MHz clock.
// Revision : 1.0
// ============================================================================
module tb_uart_transmitter;

    localparam int unsigned CLK_HZ = 1000000;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud_select;
    logic       Tx_EN;
    logic       Tx_WR;
    logic [7:0] Tx_DATA;
    logic       TxD;
    logic       Tx_BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [7:0]  data;
        int          div;
        logic [10:0] frame;   // bit 0 = start bit, bit 10 = stop bit
    } vec_t;

    vec_t vecs [8];

    uart_transmitter #(
        .CLK_FREQ_HZ (CLK_HZ)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .Tx_EN       (Tx_EN),
        .Tx_WR       (Tx_WR),
        .Tx_DATA     (Tx_DATA),
        .TxD         (TxD),
        .Tx_BUSY     (Tx_BUSY)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (Tx_BUSY !== 1'b0 && k < 50000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50000)
            check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    // Holds the line under observation; {Tx_BUSY,TxD} must stay 01.
    task automatic idle_check(input string name, input int cycles);
        logic [1:0] seen = 2'b01;
        for (int c = 0; c < cycles; c++) begin
            if ({Tx_BUSY, TxD} !== 2'b01 && seen == 2'b01)
                seen = {Tx_BUSY, TxD};
            @(negedge clk);
        end
        check(name, 32'(seen), 32'h1);
    endtask

    // Writes v.data, then checks all 11 bits for exactly v.div cycles each.
    // inject >= 0 pulses a 0x55 write at that cycle offset inside the frame.
    task automatic send_frame(input vec_t v, input int inject);
        int         n = 0;
        logic [1:0] seen;
        wait_idle();
        baud_select = v.sel;
        Tx_DATA     = v.data;
        Tx_WR       = 1'b1;
        @(negedge clk);
        Tx_WR       = 1'b0;
        Tx_DATA     = ~v.data;
        baud_select = ~v.sel;
        for (int b = 0; b < 11; b++) begin
            seen = {1'b1, v.frame[b]};
            for (int c = 0; c < v.div; c++) begin
                if ({Tx_BUSY, TxD} !== {1'b1, v.frame[b]} && seen == {1'b1, v.frame[b]})
                    seen = {Tx_BUSY, TxD};
                if (n == inject) begin
                    Tx_WR   = 1'b1;
                    Tx_DATA = 8'h55;
                end else begin
                    Tx_WR = 1'b0;
                end
                n++;
                @(negedge clk);
            end
            check($sformatf("sel%0d data%02h bit%0d {busy,txd}", v.sel, v.data, b),
                  32'(seen), 32'({1'b1, v.frame[b]}));
        end
        Tx_WR = 1'b0;
        check($sformatf("sel%0d data%02h end {busy,txd}", v.sel, v.data),
              32'({Tx_BUSY, TxD}), 32'h1);
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Frames written as {stop, parity, d7..d0, start}; parity = even.
        vecs[0] = '{3'd7, 8'hA5,    9, 11'b1_0_10100101_0};
        vecs[1] = '{3'd6, 8'h00,   17, 11'b1_0_00000000_0};
        vecs[2] = '{3'd5, 8'hFF,   26, 11'b1_0_11111111_0};
        vecs[3] = '{3'd4, 8'h5A,   52, 11'b1_0_01011010_0};
        vecs[4] = '{3'd3, 8'h01,  104, 11'b1_1_00000001_0};
        vecs[5] = '{3'd2, 8'h80,  208, 11'b1_1_10000000_0};
        vecs[6] = '{3'd1, 8'h3C,  833, 11'b1_0_00111100_0};
        vecs[7] = '{3'd0, 8'h07, 3333, 11'b1_1_00000111_0};

        reset       = 1'b1;
        Tx_EN       = 1'b0;
        Tx_WR       = 1'b0;
        Tx_DATA     = 8'h00;
        baud_select = 3'd0;
        repeat (3) @(negedge clk);
        check("reset {busy,txd}", 32'({Tx_BUSY, TxD}), 32'h1);

        reset = 1'b0;
        Tx_EN = 1'b1;
        idle_check("idle_1000", 1000);

        // Consecutive calls start on the first idle cycle: back-to-back frames.
        for (int i = 0; i < 8; i++)
            send_frame(vecs[i], -1);

        // Write during a frame is ignored; no second frame follows.
        send_frame('{3'd7, 8'h3C, 9, 11'b1_0_00111100_0}, 30);
        idle_check("no_queued_frame", 40);

        // Abort by dropping Tx_EN in BIT_3 of 0x81.
        wait_idle();
        baud_select = 3'd7;
        Tx_DATA     = 8'h81;
        Tx_WR       = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
        repeat (4 * 9 + 3) @(negedge clk);
        check("bit3_before_abort {busy,txd}", 32'({Tx_BUSY, TxD}), 32'h2);
        Tx_EN = 1'b0;
        @(negedge clk);
        check("abort {busy,txd}", 32'({Tx_BUSY, TxD}), 32'h1);
        Tx_WR   = 1'b1;
        Tx_DATA = 8'hAA;
        @(negedge clk);
        Tx_WR = 1'b0;
        idle_check("write_while_disabled", 30);
        Tx_EN = 1'b1;
        send_frame('{3'd7, 8'h81, 9, 11'b1_0_10000001_0}, -1);

        // Asynchronous reset mid-frame.
        wait_idle();
        baud_select = 3'd6;
        Tx_DATA     = 8'h5A;
        Tx_WR       = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset_midframe {busy,txd}", 32'({Tx_BUSY, TxD}), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        idle_check("no_resume_after_reset", 60);
        send_frame('{3'd5, 8'hFF, 26, 11'b1_0_11111111_0}, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 100000000, meaning the clk frequency used to derive the baud divisors.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port baud_select, input, 3 bits: rate select 000..111 = 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 baud.
REQ-005 The block SHALL have port Tx_EN, input, 1 bit: transmitter enable.
REQ-006 The block SHALL have port Tx_WR, input, 1 bit: single-cycle write strobe requesting transmission of Tx_DATA.
REQ-007 The block SHALL have port Tx_DATA, input, 8 bits: byte to send, sampled only on an accepted write.
REQ-008 The block SHALL have port TxD, output, 1 bit: registered serial line, idle high.
REQ-009 The block SHALL have port Tx_BUSY, output, 1 bit: registered; high while a frame is in progress.

Function
REQ-010 Frame SHALL be 11 bits: start (0), Tx_DATA[0]..Tx_DATA[7] LSB first, parity = XOR of the 8 data bits (even parity), stop (1).
REQ-011 Each bit SHALL last exactly DIV clk cycles, DIV = round(CLK_FREQ_HZ / baud); at 100 MHz: 333333, 83333, 20833, 10417, 5208, 2604, 1736, 868.
REQ-012 A write SHALL be accepted on a clk edge where Tx_WR=1, Tx_EN=1 and Tx_BUSY=0; Tx_DATA is latched into an internal register on that edge.
REQ-013 Tx_WR SHALL be ignored while Tx_BUSY=1 or Tx_EN=0; no queuing, no error flag.
REQ-014 On the edge after acceptance, Tx_BUSY SHALL be 1 and TxD SHALL be 0 (start bit); latency from accept to start bit is 1 cycle.
REQ-015 The bit-period counter SHALL restart on acceptance so the start bit is a full DIV cycles, independent of prior counter phase.
REQ-016 State machine: IDLE, START_BIT, BIT_0..BIT_7, PARITY, STOP_BIT; each state advances to the next on the bit-period tick; STOP_BIT returns to IDLE.
REQ-017 Tx_BUSY SHALL fall on the edge ending STOP_BIT, exactly 11*DIV cycles after it rose; a write on that same cycle SHALL be accepted (back-to-back frames, no idle gap).
REQ-018 Parity SHALL be computed from the latched byte, unaffected by Tx_DATA changes mid-frame.
REQ-019 baud_select SHALL be sampled only on acceptance; changes mid-frame take effect on the next frame.
REQ-020 Tx_EN falling mid-frame SHALL abort: next edge -> IDLE, TxD=1, Tx_BUSY=0, counter cleared.
REQ-021 In IDLE, TxD SHALL be 1 continuously; unused state encodings SHALL recover to IDLE with TxD=1.

Reset
REQ-022 While reset=1, state=IDLE, TxD=1, Tx_BUSY=0, bit counter=0, data register=0, asynchronously.
REQ-023 Reset asserted mid-frame SHALL terminate the frame immediately; no partial-frame resumption after release.

Structure
REQ-024 Baud divisor table, counter width (19 bits), and state encodings SHALL reside in a shared UART package also used by the receiver.
REQ-025 One sub-module, baud_controller_t, SHALL generate a one-cycle bit tick every DIV cycles, cleared by reset, acceptance or Tx_EN=0.
REQ-026 The FSM, shift/data register and TxD/Tx_BUSY registers SHALL live in uart_transmitter.

Verification
REQ-027 Reset then idle 1000 cycles -> TxD=1, Tx_BUSY=0 throughout.
REQ-028 baud_select=111, write 0xA5 -> TxD sequence 0,1,0,1,0,0,1,0,1,0,1, each 868 cycles; Tx_BUSY high 9548 cycles.
REQ-029 baud_select=011, write 0x00 then 0xFF on the cycle Tx_BUSY falls -> parity 0 for both, no gap, each bit 10417 cycles.
REQ-030 Write 0x3C, pulse Tx_WR with 0x55 mid-frame -> second write ignored, only 0x3C frame observed.
REQ-031 Write 0x81, drop Tx_EN during BIT_3 -> next edge TxD=1, Tx_BUSY=0; Tx_WR with Tx_EN=0 produces nothing.
REQ-032 Loopback TxD into uart_receiver at all 8 rates, bytes 0x00, 0x5A, 0xFF -> Rx_VALID pulses, Rx_DATA matches, Rx_PERROR=Rx_FERROR=0.
